// File: rtl/hex_pkg.sv
// Shared seven-segment definitions for the HEX digit encoder and the pattern reader.
package hex_pkg;

    localparam int unsigned SEG_W     = 7;
    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned HEX_W     = 8;
    localparam int unsigned NUM_CODES = 16;
    localparam int unsigned DP_BIT    = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Active-low segment codes g..a, indexed by digit 0..F.
    localparam logic [SEG_W-1:0] SEG_CODES [NUM_CODES] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {EMPTY, FULL} state_t;

    typedef struct packed {
        logic [DIGIT_W-1:0] digit;
        logic               alarm;
        logic               err;
    } result_t;

    function automatic logic [SEG_W-1:0] seg_encode(input logic [DIGIT_W-1:0] digit);
        return SEG_CODES[digit];
    endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational inverse of the segment encoder: segment field to digit plus legality.
module hex_seg_decode
    import hex_pkg::*;
(
    input  logic [SEG_W-1:0]   seg,
    output logic [DIGIT_W-1:0] digit_c,
    output logic               legal_c
);

    // Codes are unique, so at most one entry matches.
    always_comb begin
        digit_c = '0;
        legal_c = 1'b0;
        for (int unsigned i = 0; i < NUM_CODES; i++) begin
            if (seg == SEG_CODES[i]) begin
                digit_c = DIGIT_W'(i);
                legal_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hex_pattern_reader.sv
// Reads back a HEX display pattern, filters it for stability and publishes the
// decoded digit/alarm/error result on a valid/ready handshake.
module hex_pattern_reader
    import hex_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned ERR_W         = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [HEX_W-1:0]   hex_in,
    output logic [DIGIT_W-1:0] out_digit,
    output logic               out_alarm,
    output logic               out_err,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               overrun,
    output logic [ERR_W-1:0]   err_count
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    state_t             state;
    state_t             state_d;
    logic [HEX_W-1:0]   hex_q;
    logic [HEX_W-1:0]   last_pub;
    logic               none_pub;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_d;
    logic [DIGIT_W-1:0] dec_digit;
    logic               dec_legal;
    logic               stable_c;
    logic               publish_c;
    logic               handshake_c;
    logic               load_c;
    logic               drop_c;
    result_t            result;
    result_t            result_d;

    hex_seg_decode u_decode (
        .seg     (hex_in[SEG_W-1:0]),
        .digit_c (dec_digit),
        .legal_c (dec_legal)
    );

    // Run-length of identical samples, saturating at the stability threshold.
    always_comb begin
        cnt_d = CNT_W'(1);
        if (hex_in == hex_q) begin
            cnt_d = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
        end
    end

    assign stable_c    = (cnt_d == CNT_MAX);
    assign publish_c   = stable_c && (none_pub || (hex_in != last_pub));
    assign handshake_c = (state == FULL) && out_ready;

    always_comb begin
        result_d.digit = dec_legal ? dec_digit : '0;
        result_d.alarm = ~hex_in[DP_BIT];
        result_d.err   = ~dec_legal;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= EMPTY;
        end else begin
            state <= state_d;
        end
    end

    // A publish while holding an unaccepted result is dropped unless the
    // handshake frees the slot on the same edge.
    always_comb begin
        state_d = state;
        load_c  = 1'b0;
        drop_c  = 1'b0;
        case (state)
            EMPTY: begin
                if (publish_c) begin
                    load_c  = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (publish_c && handshake_c) begin
                    load_c = 1'b1;
                end else if (publish_c) begin
                    drop_c = 1'b1;
                end else if (handshake_c) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hex_q     <= '1;
            cnt       <= '0;
            last_pub  <= '1;
            none_pub  <= 1'b1;
            result    <= '0;
            overrun   <= 1'b0;
            err_count <= '0;
        end else begin
            hex_q <= hex_in;
            cnt   <= cnt_d;
            if (load_c) begin
                result   <= result_d;
                last_pub <= hex_in;
                none_pub <= 1'b0;
                if (result_d.err && (err_count != '1)) begin
                    err_count <= err_count + ERR_W'(1);
                end
            end
            if (drop_c) begin
                overrun <= 1'b1;
            end
        end
    end

    assign out_valid = (state == FULL);
    assign out_digit = result.digit;
    assign out_alarm = result.alarm;
    assign out_err   = result.err;

endmodule
